ace_txn_allocator_mc: RTL and testbench
=======================================

Name: ace_txn_allocator_mc

Overview:
- Multi-channel successor to the single-channel RD/WR/SN transaction allocator.
- Arbitrates round-robin among NUM_CH requesters and assigns each winner a free descriptor index plus a contiguous data-RAM offset.
- Offsets come from a ring with wrap padding; descriptors may complete out of order, and RAM space is reclaimed in allocation order.
- In SN mode the ring is bypassed and offsets are fixed per descriptor slot.

Parameters:
- NUM_CH, 2, number of requesting channels (≥1).
- SN_MODE, 0, 1 = fixed slot offsets (idx*CACHE_LINE_SIZE*8/DATA_WIDTH), no ring accounting.
- DATA_WIDTH, 128, data RAM beat width in bits.
- RAM_SIZE, 16384, data RAM bytes; DEPTH = RAM_SIZE*8/DATA_WIDTH beats.
- MAX_DESC, 16, number of descriptors.
- CACHE_LINE_SIZE, 64, bytes per slot in SN_MODE.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request; level, held until granted.
- req_len  in  NUM_CH*8  per-channel AXLEN, channel c at [8c+7:8c]; beats = AXLEN+1.
- desc_avail  in  MAX_DESC  1 = descriptor free on the software side.
- rel_valid  in  1  release pulse: data for rel_idx has been consumed.
- rel_idx  in  CLOG2(MAX_DESC)  descriptor being released.
- alc_valid  out  1  one-cycle grant pulse.
- alc_ch  out  max(1,CLOG2(NUM_CH))  granted channel.
- alc_idx  out  CLOG2(MAX_DESC)  allocated descriptor.
- alc_offset  out  CLOG2(DEPTH)  start beat in data RAM.
- free_beats  out  CLOG2(DEPTH)+1  current unreserved beats.
- busy  out  1  state machine not in IDLE.

Behaviour:
- Reset (async assert, sync release): alc_valid=0; alc_ch, alc_idx, alc_offset=0; free_beats=DEPTH; head=0; order FIFO empty; inflight and released bitmaps 0; RR pointer=0; state IDLE. An assert mid-allocation drops any pending grant.
- FSM IDLE -> ARB: entered when any req_valid=1.
- FSM ARB: pick the first requesting channel at or after the RR pointer (wrapping); latch its channel number and beats.
  - If its req_valid dropped, return to IDLE.
- FSM ALLOC: wait until a descriptor is available and space fits, then go to GRANT.
  - Candidate descriptor: lowest set bit of desc_avail & ~inflight.
  - Ring mode, no wrap (head+beats ≤ DEPTH): offset=head, consumed=beats, new head=(head+beats) mod DEPTH.
  - Ring mode, wrap (head+beats > DEPTH): offset=0, consumed=(DEPTH-head)+beats, new head=beats.
  - Ring mode fit condition: consumed ≤ free_beats.
  - SN mode: offset = idx*(CACHE_LINE_SIZE*8/DATA_WIDTH); fit is always true.
- FSM GRANT: drive alc_valid=1 for one cycle with alc_ch, alc_idx, alc_offset.
  - Set inflight[idx]; push {idx, consumed} to the order FIFO (depth MAX_DESC); subtract consumed from free_beats; update head.
  - RR pointer = winner+1 mod NUM_CH; return to IDLE.
- Latency: req_valid to alc_valid is 3 cycles when resources are free.
  - The requester must deassert, or present its next request, by the cycle after the alc_valid that names its channel.
- Release path: rel_valid with inflight[rel_idx]=1 sets released[rel_idx]. rel_valid on a descriptor that is not inflight is ignored.
- Retire engine (at most one per cycle): if FIFO non-empty and released[front]=1, pop, add front.consumed to free_beats, clear inflight and released for that idx.
  - Earliest retire is the cycle after rel_valid.
  - An out-of-order release waits until all older entries retire.
- Descriptor reuse: inflight clears only at retire, so an idx is never re-granted before its space is reclaimed.
- Same cycle GRANT and retire: free_beats = free_beats - consumed_new + consumed_retired. Never under- or overflows.
- Full: if no descriptor or insufficient space, stay in ALLOC with alc_valid=0 and keep the winner. There is no re-arbitration, so requests are not starved.
- Empty: free_beats=DEPTH and head keeps its position; wrap padding still applies.
- SN_MODE=1: head and free_beats are held at reset values; only descriptor allocation applies.

Test Plan:
- Single grant: ch0 req_len=3, desc_avail=all ones -> alc_valid 3 cycles later, alc_ch=0, alc_idx=0, alc_offset=0, free_beats=1020.
- Round robin: ch0 and ch1 both held with len 0 -> grants alternate ch0,ch1,ch0 with idx 0,1,2 and offsets 0,1,2.
- Wrap: head=1020 (DEPTH=1024), request len=7 -> alc_offset=0, consumed=12, free_beats drops by 12, head=8.
- Out of order release: grant idx0 (16 beats) and idx1 (16 beats), rel idx1 then rel idx0 -> no free_beats change after rel idx1 alone; after rel idx0 two retires on consecutive cycles restore free_beats to 1024.
- Stall: desc_avail=16'h0001 with idx0 inflight -> ch0 stalls in ALLOC, busy=1; after rel idx0 and its retire -> grant idx0.
- SN_MODE=1, desc_avail=16'h0008 -> alc_idx=3, alc_offset=12; async resetn pulse mid-ALLOC -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ace_txn_allocator_mc.sv
// Multi-channel transaction allocator: round-robin picks a requester, then it is granted a free
// descriptor and a contiguous data-RAM window from a wrap-padded ring (or a fixed slot in SN mode).
module ace_txn_allocator_mc #(
    parameter int NUM_CH          = 2,
    parameter int SN_MODE         = 0,
    parameter int DATA_WIDTH      = 128,
    parameter int RAM_SIZE        = 16384,
    parameter int MAX_DESC        = 16,
    parameter int CACHE_LINE_SIZE = 64
) (
    input  logic                                           clk,
    input  logic                                           resetn,
    input  logic [NUM_CH-1:0]                              req_valid,
    input  logic [NUM_CH*8-1:0]                            req_len,
    input  logic [MAX_DESC-1:0]                            desc_avail,
    input  logic                                           rel_valid,
    input  logic [$clog2(MAX_DESC)-1:0]                    rel_idx,
    output logic                                           alc_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] alc_ch,
    output logic [$clog2(MAX_DESC)-1:0]                    alc_idx,
    output logic [$clog2(RAM_SIZE*8/DATA_WIDTH)-1:0]       alc_offset,
    output logic [$clog2(RAM_SIZE*8/DATA_WIDTH):0]         free_beats,
    output logic                                           busy
);

    localparam int DEPTH      = RAM_SIZE * 8 / DATA_WIDTH;
    localparam int IDX_W      = $clog2(MAX_DESC);
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OFF_W      = $clog2(DEPTH);
    localparam int CNT_W      = OFF_W + 1;
    localparam int AW         = ((CNT_W > 9) ? CNT_W : 9) + 1;
    localparam int SLOT_BEATS = CACHE_LINE_SIZE * 8 / DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ALLOC = 2'd2,
        ST_GRANT = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CH_W-1:0]     rr_ptr_r;
    logic [CH_W-1:0]     win_ch_r;
    logic [8:0]          win_beats_r;
    logic [OFF_W-1:0]    head_r;
    logic [CNT_W-1:0]    free_r;
    logic [MAX_DESC-1:0] inflight_r;
    logic [MAX_DESC-1:0] released_r;
    logic [IDX_W-1:0]    fifo_idx_r [MAX_DESC];
    logic [CNT_W-1:0]    fifo_cons_r [MAX_DESC];
    logic [IDX_W-1:0]    wr_ptr_r;
    logic [IDX_W-1:0]    rd_ptr_r;
    logic [IDX_W:0]      fifo_cnt_r;
    logic                alc_valid_r;
    logic [CH_W-1:0]     alc_ch_r;
    logic [IDX_W-1:0]    alc_idx_r;
    logic [OFF_W-1:0]    alc_off_r;
    logic                busy_r;

    logic [2*NUM_CH-1:0] req_rot_s;
    logic                arb_found_s;
    logic [CH_W-1:0]     arb_ch_s;
    logic [7:0]          arb_len_s;
    logic [MAX_DESC-1:0] avail_s;
    logic                cand_found_s;
    logic [IDX_W-1:0]    cand_idx_s;
    logic [AW-1:0]       sum_s;
    logic                wrap_s;
    logic [AW-1:0]       consumed_s;
    logic                fit_s;
    logic [OFF_W-1:0]    offset_s;
    logic [OFF_W-1:0]    head_nxt_s;
    logic                commit_s;
    logic [IDX_W-1:0]    front_idx_s;
    logic [CNT_W-1:0]    front_cons_s;
    logic                retire_s;
    logic [CNT_W-1:0]    free_nxt_s;

    // Round-robin search: rotate requests so the RR pointer lands at bit 0, take the first set bit.
    always_comb begin
        req_rot_s   = {req_valid, req_valid} >> rr_ptr_r;
        arb_found_s = 1'b0;
        arb_ch_s    = {CH_W{1'b0}};
        arb_len_s   = 8'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!arb_found_s && req_rot_s[i]) begin
                arb_found_s = 1'b1;
                arb_ch_s    = CH_W'((int'(rr_ptr_r) + i) % NUM_CH);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (CH_W'(j) == arb_ch_s) begin
                arb_len_s = req_len[8*j +: 8];
            end else begin
                arb_len_s = arb_len_s;
            end
        end
    end

    // Lowest free descriptor plus ring placement for the latched winner.
    always_comb begin
        avail_s      = desc_avail & ~inflight_r;
        cand_found_s = 1'b0;
        cand_idx_s   = {IDX_W{1'b0}};
        for (int i = 0; i < MAX_DESC; i++) begin
            if (!cand_found_s && avail_s[i]) begin
                cand_found_s = 1'b1;
                cand_idx_s   = IDX_W'(i);
            end else begin
                cand_found_s = cand_found_s;
            end
        end
        sum_s  = AW'(head_r) + AW'(win_beats_r);
        wrap_s = (sum_s > AW'(DEPTH));
        // A wrapping burst also swallows the tail padding up to the end of the RAM.
        consumed_s = wrap_s ? (AW'(DEPTH) - AW'(head_r) + AW'(win_beats_r)) : AW'(win_beats_r);
        head_nxt_s = wrap_s ? OFF_W'(win_beats_r) : sum_s[OFF_W-1:0];
        if (SN_MODE != 0) begin
            fit_s    = 1'b1;
            offset_s = OFF_W'(int'(cand_idx_s) * SLOT_BEATS);
        end else begin
            fit_s    = (consumed_s <= AW'(free_r));
            offset_s = wrap_s ? {OFF_W{1'b0}} : head_r;
        end
        commit_s = (state_r == ST_ALLOC) && cand_found_s && fit_s;
    end

    // Retire decision on the oldest outstanding allocation and the combined space update.
    always_comb begin
        front_idx_s  = fifo_idx_r[rd_ptr_r];
        front_cons_s = fifo_cons_r[rd_ptr_r];
        retire_s     = (fifo_cnt_r != {(IDX_W+1){1'b0}}) && released_r[front_idx_s];
        free_nxt_s   = CNT_W'(AW'(free_r)
                              - (commit_s ? consumed_s : {AW{1'b0}})
                              + (retire_s ? AW'(front_cons_s) : {AW{1'b0}}));
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = (|req_valid) ? ST_ARB : ST_IDLE;
            ST_ARB:   state_nxt_s = arb_found_s ? ST_ALLOC : ST_IDLE;
            ST_ALLOC: state_nxt_s = commit_s ? ST_GRANT : ST_ALLOC;
            ST_GRANT: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, winner latch and round-robin pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {CH_W{1'b0}};
            win_ch_r    <= {CH_W{1'b0}};
            win_beats_r <= 9'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_ARB && arb_found_s) begin
                win_ch_r    <= arb_ch_s;
                win_beats_r <= {1'b0, arb_len_s} + 9'd1;
            end
            if (commit_s) begin
                rr_ptr_r <= (win_ch_r == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : (win_ch_r + CH_W'(1));
            end
        end
    end

    // Registered grant outputs; fields hold their last value between grants.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alc_valid_r <= 1'b0;
            alc_ch_r    <= {CH_W{1'b0}};
            alc_idx_r   <= {IDX_W{1'b0}};
            alc_off_r   <= {OFF_W{1'b0}};
        end else begin
            alc_valid_r <= commit_s;
            if (commit_s) begin
                alc_ch_r  <= win_ch_r;
                alc_idx_r <= cand_idx_s;
                alc_off_r <= offset_s;
            end
        end
    end

    // Ring head and free space; SN mode never touches them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_r <= {OFF_W{1'b0}};
            free_r <= CNT_W'(DEPTH);
        end else if (SN_MODE == 0) begin
            free_r <= free_nxt_s;
            if (commit_s) begin
                head_r <= head_nxt_s;
            end
        end
    end

    // Descriptor bookkeeping: a release only marks, the in-order retire actually frees.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_r <= {MAX_DESC{1'b0}};
            released_r <= {MAX_DESC{1'b0}};
        end else begin
            if (commit_s) begin
                inflight_r[cand_idx_s] <= 1'b1;
            end
            if (rel_valid && inflight_r[rel_idx]) begin
                released_r[rel_idx] <= 1'b1;
            end
            if (retire_s) begin
                inflight_r[front_idx_s] <= 1'b0;
                released_r[front_idx_s] <= 1'b0;
            end
        end
    end

    // Allocation-order FIFO; never overflows because each entry holds an inflight descriptor.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r   <= {IDX_W{1'b0}};
            rd_ptr_r   <= {IDX_W{1'b0}};
            fifo_cnt_r <= {(IDX_W+1){1'b0}};
            for (int i = 0; i < MAX_DESC; i++) begin
                fifo_idx_r[i]  <= {IDX_W{1'b0}};
                fifo_cons_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            if (commit_s) begin
                fifo_idx_r[wr_ptr_r]  <= cand_idx_s;
                fifo_cons_r[wr_ptr_r] <= (SN_MODE != 0) ? {CNT_W{1'b0}} : CNT_W'(consumed_s);
                wr_ptr_r <= (wr_ptr_r == IDX_W'(MAX_DESC - 1)) ? {IDX_W{1'b0}} : (wr_ptr_r + IDX_W'(1));
            end
            if (retire_s) begin
                rd_ptr_r <= (rd_ptr_r == IDX_W'(MAX_DESC - 1)) ? {IDX_W{1'b0}} : (rd_ptr_r + IDX_W'(1));
            end
            case ({commit_s, retire_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (IDX_W+1)'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (IDX_W+1)'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign alc_valid  = alc_valid_r;
    assign alc_ch     = alc_ch_r;
    assign alc_idx    = alc_idx_r;
    assign alc_offset = alc_off_r;
    assign free_beats = free_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_ace_txn_allocator_mc.sv
// Directed bench for ace_txn_allocator_mc: a ring-mode instance and an SN-mode instance share stimulus.
module tb_ace_txn_allocator_mc;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [15:0] req_len;
    logic [15:0] desc_avail;
    logic        rel_valid;
    logic [3:0]  rel_idx;

    logic        alc_valid, alc_valid_sn;
    logic [0:0]  alc_ch, alc_ch_sn;
    logic [3:0]  alc_idx, alc_idx_sn;
    logic [9:0]  alc_offset, alc_offset_sn;
    logic [10:0] free_beats, free_beats_sn;
    logic        busy, busy_sn;

    int checks = 0;
    int errors = 0;
    int g_ch, g_idx, g_off, g_free;

    always #5 clk = ~clk;

    ace_txn_allocator_mc #(.SN_MODE(0)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_len(req_len),
        .desc_avail(desc_avail), .rel_valid(rel_valid), .rel_idx(rel_idx),
        .alc_valid(alc_valid), .alc_ch(alc_ch), .alc_idx(alc_idx),
        .alc_offset(alc_offset), .free_beats(free_beats), .busy(busy)
    );

    ace_txn_allocator_mc #(.SN_MODE(1)) dut_sn (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_len(req_len),
        .desc_avail(desc_avail), .rel_valid(rel_valid), .rel_idx(rel_idx),
        .alc_valid(alc_valid_sn), .alc_ch(alc_ch_sn), .alc_idx(alc_idx_sn),
        .alc_offset(alc_offset_sn), .free_beats(free_beats_sn), .busy(busy_sn)
    );

    task automatic reset_dut();
        resetn     = 1'b0;
        req_valid  = 2'b00;
        req_len    = 16'h0000;
        desc_avail = 16'hFFFF;
        rel_valid  = 1'b0;
        rel_idx    = 4'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Raise one request, wait for its grant, capture it, then drop the request.
    task automatic do_grant(input int ch, input int len, output bit got);
        req_len[8*ch +: 8] = 8'(len);
        req_valid[ch] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (alc_valid === 1'b1) begin
                got = 1'b1;
                g_ch = int'(alc_ch); g_idx = int'(alc_idx);
                g_off = int'(alc_offset); g_free = int'(free_beats);
            end
        end
        req_valid[ch] = 1'b0;
        @(negedge clk);
    endtask

    task automatic rel_pulse(input int idx);
        rel_valid = 1'b1;
        rel_idx   = 4'(idx);
        @(negedge clk);
        rel_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (alc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d exp 0", alc_valid); end
        checks++; if (alc_ch !== 1'b0) begin errors++; $display("FAIL rst_ch got %0d exp 0", alc_ch); end
        checks++; if (alc_idx !== 4'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", alc_idx); end
        checks++; if (alc_offset !== 10'd0) begin errors++; $display("FAIL rst_off got %0d exp 0", alc_offset); end
        checks++; if (free_beats !== 11'd1024) begin errors++; $display("FAIL rst_free got %0d exp 1024", free_beats); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d exp 0", busy); end
    endtask

    task automatic test_single();
        reset_dut();
        req_len[7:0] = 8'd3;
        req_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (alc_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0d exp 0", alc_valid); end
        @(negedge clk);
        checks++; if (alc_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %0d exp 1", alc_valid); end
        checks++; if (alc_ch !== 1'b0) begin errors++; $display("FAIL single_ch got %0d exp 0", alc_ch); end
        checks++; if (alc_idx !== 4'd0) begin errors++; $display("FAIL single_idx got %0d exp 0", alc_idx); end
        checks++; if (alc_offset !== 10'd0) begin errors++; $display("FAIL single_off got %0d exp 0", alc_offset); end
        checks++; if (free_beats !== 11'd1020) begin errors++; $display("FAIL single_free got %0d exp 1020", free_beats); end
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (alc_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %0d exp 0", alc_valid); end
    endtask

    task automatic test_round_robin();
        bit got;
        reset_dut();
        req_len   = 16'h0000;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (alc_valid === 1'b1) begin
                    got = 1'b1;
                    g_ch = int'(alc_ch); g_idx = int'(alc_idx); g_off = int'(alc_offset);
                end
            end
            checks++; if (!got) begin errors++; $display("FAIL rr_timeout grant %0d got none exp grant", k); end
            checks++; if (g_ch !== k % 2) begin errors++; $display("FAIL rr_ch got %0d exp %0d", g_ch, k % 2); end
            checks++; if (g_idx !== k) begin errors++; $display("FAIL rr_idx got %0d exp %0d", g_idx, k); end
            checks++; if (g_off !== k) begin errors++; $display("FAIL rr_off got %0d exp %0d", g_off, k); end
        end
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (free_beats !== 11'd1021) begin errors++; $display("FAIL rr_free got %0d exp 1021", free_beats); end
    endtask

    task automatic test_wrap();
        bit got;
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            do_grant(0, 254, got);
            checks++; if (!got || g_off !== 255 * k) begin errors++; $display("FAIL wrap_fill_off got %0d exp %0d", g_off, 255 * k); end
        end
        checks++; if (g_free !== 4) begin errors++; $display("FAIL wrap_fill_free got %0d exp 4", g_free); end
        for (int k = 0; k < 4; k++) rel_pulse(k);
        repeat (3) @(negedge clk);
        checks++; if (free_beats !== 11'd1024) begin errors++; $display("FAIL wrap_empty_free got %0d exp 1024", free_beats); end
        do_grant(0, 7, got);
        checks++; if (!got || g_off !== 0) begin errors++; $display("FAIL wrap_off got %0d exp 0", g_off); end
        checks++; if (g_free !== 1012) begin errors++; $display("FAIL wrap_free got %0d exp 1012", g_free); end
        do_grant(0, 0, got);
        checks++; if (!got || g_off !== 8) begin errors++; $display("FAIL wrap_head got %0d exp 8", g_off); end
        checks++; if (g_free !== 1011) begin errors++; $display("FAIL wrap_free2 got %0d exp 1011", g_free); end
    endtask

    task automatic test_out_of_order();
        bit got;
        reset_dut();
        do_grant(0, 15, got);
        checks++; if (!got || g_idx !== 0 || g_off !== 0) begin errors++; $display("FAIL ooo_g0 got idx %0d off %0d exp idx 0 off 0", g_idx, g_off); end
        do_grant(1, 15, got);
        checks++; if (!got || g_idx !== 1 || g_off !== 16) begin errors++; $display("FAIL ooo_g1 got idx %0d off %0d exp idx 1 off 16", g_idx, g_off); end
        rel_pulse(1);
        repeat (3) @(negedge clk);
        checks++; if (free_beats !== 11'd992) begin errors++; $display("FAIL ooo_hold got %0d exp 992", free_beats); end
        rel_pulse(0);
        checks++; if (free_beats !== 11'd992) begin errors++; $display("FAIL ooo_pre got %0d exp 992", free_beats); end
        @(negedge clk);
        checks++; if (free_beats !== 11'd1008) begin errors++; $display("FAIL ooo_ret0 got %0d exp 1008", free_beats); end
        @(negedge clk);
        checks++; if (free_beats !== 11'd1024) begin errors++; $display("FAIL ooo_ret1 got %0d exp 1024", free_beats); end
    endtask

    task automatic test_stall();
        bit got;
        bit seen;
        reset_dut();
        do_grant(0, 3, got);
        checks++; if (!got || g_idx !== 0) begin errors++; $display("FAIL stall_first got %0d exp 0", g_idx); end
        desc_avail   = 16'h0001;
        req_len[7:0] = 8'd3;
        req_valid[0] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (alc_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stall_nogrant got %0d exp 0", seen); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %0d exp 1", busy); end
        rel_pulse(0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (alc_valid === 1'b1) begin
                got = 1'b1;
                g_idx = int'(alc_idx); g_off = int'(alc_offset); g_free = int'(free_beats);
            end
        end
        req_valid[0] = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL stall_timeout got none exp grant"); end
        checks++; if (g_idx !== 0 || g_off !== 4) begin errors++; $display("FAIL stall_grant got idx %0d off %0d exp idx 0 off 4", g_idx, g_off); end
        checks++; if (g_free !== 1020) begin errors++; $display("FAIL stall_free got %0d exp 1020", g_free); end
        desc_avail = 16'hFFFF;
        @(negedge clk);
    endtask

    task automatic test_sn_mode();
        bit got;
        reset_dut();
        desc_avail   = 16'h0008;
        req_len[7:0] = 8'd3;
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (alc_valid_sn === 1'b1) begin
                got = 1'b1;
                g_idx = int'(alc_idx_sn); g_off = int'(alc_offset_sn); g_free = int'(free_beats_sn);
            end
        end
        req_valid[0] = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL sn_timeout got none exp grant"); end
        checks++; if (g_idx !== 3) begin errors++; $display("FAIL sn_idx got %0d exp 3", g_idx); end
        checks++; if (g_off !== 12) begin errors++; $display("FAIL sn_off got %0d exp 12", g_off); end
        checks++; if (g_free !== 1024) begin errors++; $display("FAIL sn_free got %0d exp 1024", g_free); end
        @(negedge clk);
        req_valid[0] = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy_sn !== 1'b1) begin errors++; $display("FAIL sn_stall_busy got %0d exp 1", busy_sn); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (busy_sn !== 1'b0) begin errors++; $display("FAIL sn_arst_busy got %0d exp 0", busy_sn); end
        checks++; if (alc_valid_sn !== 1'b0) begin errors++; $display("FAIL sn_arst_valid got %0d exp 0", alc_valid_sn); end
        checks++; if (alc_idx_sn !== 4'd0) begin errors++; $display("FAIL sn_arst_idx got %0d exp 0", alc_idx_sn); end
        checks++; if (alc_offset_sn !== 10'd0) begin errors++; $display("FAIL sn_arst_off got %0d exp 0", alc_offset_sn); end
        checks++; if (alc_ch_sn !== 1'b0) begin errors++; $display("FAIL sn_arst_ch got %0d exp 0", alc_ch_sn); end
        checks++; if (free_beats_sn !== 11'd1024) begin errors++; $display("FAIL sn_arst_free got %0d exp 1024", free_beats_sn); end
        req_valid = 2'b00;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_out_of_order();
        test_stall();
        test_sn_mode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
